// File: rtl/instr_encoder_loader.sv
// Assembles MIPS instruction words from class code + fields and streams them
// through a small FIFO into instruction memory at consecutive word addresses.
module instr_encoder_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  finish_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            op_sel_i,
    input  logic [4:0]            rs_i,
    input  logic [4:0]            rt_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            shamt_i,
    input  logic [5:0]            funct_i,
    input  logic [15:0]           imm_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic                  mem_ready_i,
    output logic [6:0]            word_count_o,
    output logic                  full_o,
    output logic                  err_o,
    output logic                  done_o,
    output logic [1:0]            dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t             state, state_nxt;
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]        enc_word;
    logic               op_legal;
    logic               active, fifo_empty, fifo_full;
    logic [7:0]         total;
    logic               accept, push, pop;

    // Class code to opcode; LUI has no rs operand so it is forced to zero.
    always_comb begin
        op_legal = 1'b1;
        enc_word = '0;
        case (op_sel_i)
            3'b111:  enc_word = {6'h00, rs_i, rt_i, rd_i, shamt_i, funct_i};
            3'b100:  enc_word = {6'h08, rs_i, rt_i, imm_i};
            3'b001:  enc_word = {6'h0D, rs_i, rt_i, imm_i};
            3'b010:  enc_word = {6'h0F, 5'd0, rt_i, imm_i};
            3'b011:  enc_word = {6'h0C, rs_i, rt_i, imm_i};
            3'b101:  enc_word = {6'h23, rs_i, rt_i, imm_i};
            default: op_legal = 1'b0;
        endcase
    end

    assign active     = (state == LOAD) || (state == DRAIN);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    // Buffered words count against capacity so nothing beyond MAX_WORDS is taken.
    assign total      = {1'b0, word_count_o} + 8'(fifo_count);

    assign req_ready_o = (state == LOAD) && !fifo_full && (total < 8'(MAX_WORDS));
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && op_legal;
    assign mem_we_o    = active && !fifo_empty;
    assign pop         = mem_we_o && mem_ready_i;
    assign mem_data_o  = mem_we_o ? fifo_mem[rd_ptr] : 32'd0;
    assign mem_addr_o  = wr_addr;
    assign full_o      = (total == 8'(MAX_WORDS));
    assign done_o      = (state == DONE);
    assign dbg_state   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = LOAD;
            LOAD:    if (finish_i) state_nxt = DRAIN;
            DRAIN:   if (fifo_empty) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            wr_addr      <= '0;
            word_count_o <= '0;
            err_o        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start_i) begin
                wr_addr      <= base_addr_i;
                word_count_o <= '0;
                err_o        <= 1'b0;
            end
            if (accept && !op_legal)
                err_o <= 1'b1;
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                wr_addr      <= wr_addr + ADDR_WIDTH'(4);
                word_count_o <= word_count_o + 7'd1;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: mem_data_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= enc_word;
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: expected {addr, data} pairs are
// queued at request acceptance and compared as memory writes commit.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i, finish_i, req_valid_i, req_ready_o;
    logic [31:0] base_addr_i;
    logic [2:0]  op_sel_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic        mem_we_o, mem_ready_i, full_o, err_o, done_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [6:0]  word_count_o;
    logic [1:0]  dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_addr;
    logic        prev_stall;
    logic [31:0] prev_addr, prev_data;
    logic [63:0] head;

    always #5 clk = ~clk;

    instr_encoder_loader dut (
        .clk(clk), .reset(reset), .start_i(start_i), .base_addr_i(base_addr_i),
        .finish_i(finish_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .shamt_i(shamt_i), .funct_i(funct_i), .imm_i(imm_i),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ready_i(mem_ready_i), .word_count_o(word_count_o), .full_o(full_o),
        .err_o(err_o), .done_o(done_o), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [4:0] rs, rt, rd, sh,
                                          input logic [5:0] fn, input logic [15:0] imm);
        case (op)
            3'b111:  return {6'h00, rs, rt, rd, sh, fn};
            3'b100:  return {6'h08, rs, rt, imm};
            3'b001:  return {6'h0D, rs, rt, imm};
            3'b010:  return {6'h0F, 5'd0, rt, imm};
            3'b011:  return {6'h0C, rs, rt, imm};
            default: return {6'h23, rs, rt, imm};
        endcase
    endfunction

    // Write monitor: sampled on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (done_o) done_cnt++;
            if (prev_stall)
                check("stall_hold", {mem_we_o, mem_addr_o, mem_data_o}, {1'b1, prev_addr, prev_data});
            if (mem_we_o && mem_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", mem_we_o, 1'b0);
                end else begin
                    head = exp_q.pop_front();
                    check("write", {mem_addr_o, mem_data_o}, head);
                end
            end
            prev_stall = mem_we_o && !mem_ready_i;
            prev_addr  = mem_addr_o;
            prev_data  = mem_data_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_session(input logic [31:0] base);
        base_addr_i = base;
        start_i     = 1'b1;
        exp_addr    = base;
        tick(1);
        start_i     = 1'b0;
    endtask

    task automatic finish_session();
        finish_i = 1'b1;
        tick(1);
        finish_i = 1'b0;
    endtask

    task automatic set_fields(input logic [2:0] op, input logic [4:0] rs, rt, rd, sh,
                              input logic [5:0] fn, input logic [15:0] imm);
        op_sel_i = op; rs_i = rs; rt_i = rt; rd_i = rd;
        shamt_i = sh; funct_i = fn; imm_i = imm;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rs, rt, rd, sh,
                        input logic [5:0] fn, input logic [15:0] imm,
                        input logic [31:0] exp_word, input bit legal);
        bit accepted = 1'b0;
        set_fields(op, rs, rt, rd, sh, fn, imm);
        req_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready_o) begin
                if (legal) begin
                    exp_q.push_back({exp_addr, exp_word});
                    exp_addr += 32'd4;
                end
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check("req_timeout", req_ready_o, 1'b1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done(input logic [6:0] exp_wc, input logic exp_err);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_o) break;
        end
        check("done_seen", done_o, 1'b1);
        check("word_count", word_count_o, exp_wc);
        check("err", err_o, exp_err);
        check("queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse", done_o, 1'b0);
        check("wc_hold", word_count_o, exp_wc);
        tick(1);
    endtask

    initial begin
        logic [2:0] ops [6];
        logic [2:0] op;
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] fn;
        logic [15:0] imm;
        int d0;
        ops = '{3'b111, 3'b100, 3'b001, 3'b010, 3'b011, 3'b101};

        // Reset
        reset = 1'b0; start_i = 1'b0; finish_i = 1'b0; req_valid_i = 1'b0;
        base_addr_i = '0; mem_ready_i = 1'b1; exp_addr = '0;
        set_fields(3'b000, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
        #12;
        check("reset_outs", {req_ready_o, mem_we_o, mem_addr_o, mem_data_o, word_count_o,
                             full_o, err_o, done_o}, '0);
        @(posedge clk); #1;
        reset = 1'b1;
        tick(1);

        // Basic load
        start_session(32'h0040_0000);
        @(negedge clk);
        check("load_ready", {req_ready_o, mem_we_o}, 2'b10);
        tick(1);
        send(3'b100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 32'h2008_0005, 1);
        send(3'b111, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 32'h0109_5020, 1);
        finish_session();
        wait_done(7'd2, 1'b0);

        // Field forcing
        start_session(32'h0000_1000);
        send(3'b010, 5'd5, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1001, 32'h3C01_1001, 1);
        send(3'b101, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 32'h8FA8_0004, 1);
        send(3'b001, 5'd1, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0024, 32'h3429_0024, 1);
        send(3'b011, 5'd0, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 32'h3002_FFFF, 1);
        finish_session();
        wait_done(7'd4, 1'b0);

        // Backpressure
        start_session(32'h0000_2000);
        mem_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++)
            send(3'b100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'(k), 32'h2008_0000 | 32'(k), 1);
        set_fields(3'b100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5);
        req_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_held", {req_ready_o, mem_we_o, mem_addr_o}, {1'b0, 1'b1, 32'h0000_2000});
        end
        @(posedge clk); #1;
        mem_ready_i = 1'b1;
        send(3'b100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 32'h2008_0005, 1);
        finish_session();
        wait_done(7'd5, 1'b0);

        // Illegal op
        start_session(32'h0000_3000);
        send(3'b100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd1, 32'h2008_0001, 1);
        send(3'b110, 5'd3, 5'd4, 5'd5, 5'd0, 6'd0, 16'd7, 32'd0, 0);
        check("err_set", err_o, 1'b1);
        send(3'b100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd2, 32'h2008_0002, 1);
        finish_session();
        wait_done(7'd2, 1'b1);
        start_session(32'h0000_3100);
        check("err_cleared", {err_o, word_count_o}, '0);
        finish_session();
        wait_done(7'd0, 1'b0);

        // Capacity: buffered words count toward MAX_WORDS
        start_session(32'h0001_0000);
        for (int k = 0; k < 62; k++) begin
            op = ops[$urandom_range(0, 5)];
            rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31)); sh = 5'($urandom_range(0, 31));
            fn = 6'($urandom_range(0, 63)); imm = 16'($urandom_range(0, 65535));
            send(op, rs, rt, rd, sh, fn, imm, model(op, rs, rt, rd, sh, fn, imm), 1);
        end
        tick(3);
        mem_ready_i = 1'b0;
        @(negedge clk);
        check("cap_wc62", {word_count_o, full_o}, {7'd62, 1'b0});
        tick(1);
        send(3'b100, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h00AA, 32'h2022_00AA, 1);
        send(3'b001, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00BB, 32'h3464_00BB, 1);
        set_fields(3'b100, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h0001);
        req_valid_i = 1'b1;
        @(negedge clk);
        check("cap_full_buffered", {req_ready_o, full_o}, 2'b01);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        mem_ready_i = 1'b1;
        tick(3);
        @(negedge clk);
        check("cap_full_committed", {word_count_o, full_o, req_ready_o}, {7'd64, 1'b1, 1'b0});
        tick(1);
        finish_session();
        wait_done(7'd64, 1'b0);

        // Reset mid-session
        start_session(32'h0000_5000);
        mem_ready_i = 1'b0;
        for (int k = 1; k <= 3; k++)
            send(3'b100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'(k), 32'h2008_0000 | 32'(k), 1);
        @(negedge clk);
        check("pre_rst_we", mem_we_o, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async", {mem_we_o, mem_addr_o, mem_data_o, word_count_o, req_ready_o,
                            done_o, full_o, err_o}, '0);
        exp_q.delete();
        d0 = done_cnt;
        tick(2);
        reset = 1'b1;
        mem_ready_i = 1'b1;
        tick(5);
        check("rst_no_done", done_cnt, d0);
        check("rst_idle", {mem_we_o, word_count_o}, '0);
        start_session(32'h0000_6000);
        send(3'b100, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd9, 32'h2008_0009, 1);
        finish_session();
        wait_done(7'd1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
